fir_output_decimator: RTL and testbench

Output stage directly downstream of the systolic FIR filter. It consumes the filter's free-running `fp_32_t` output once per clock and discards the pipeline warm-up samples. It decimates the remaining stream by a fixed factor and buffers the result in a small FIFO with a valid/ready handshake. Downstream consumers can then stall without losing filter output until the buffer overflows.

---
 rtl/fir_output_decimator_pkg.sv | 26 ++
 rtl/fir_output_decimator_fifo.sv | 84 ++++++++
 rtl/fir_output_decimator.sv | 110 +++++++++++
 tb/tb_fir_output_decimator.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fir_output_decimator_pkg.sv
// Shared types, limits and saturation helper for the FIR output decimator.
package fir_output_decimator_pkg;

    typedef logic signed [31:0] fp_32_t;

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        STREAM
    } fir_decim_state_t;

    localparam fp_32_t FP_32_MAX = 32'sh7FFF_FFFF;
    localparam fp_32_t FP_32_MIN = 32'sh8000_0000;

    // Clamp a widened group sum back into the signed 32-bit range.
    function automatic fp_32_t sat_fp_32(input logic signed [33:0] value);
        if (value > 34'(FP_32_MAX)) begin
            return FP_32_MAX;
        end
        if (value < 34'(FP_32_MIN)) begin
            return FP_32_MIN;
        end
        return fp_32_t'(value[31:0]);
    endfunction

endpackage

// File: rtl/fir_output_decimator_fifo.sv
// fir_out_fifo: synchronous FIFO with a registered head word, occupancy output,
// sticky overflow flag, and push-while-full allowed when a pop happens on the same edge.
module fir_out_fifo
    import fir_output_decimator_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic                   clear,
    input  logic                   push,
    input  logic [31:0]            push_data,
    input  logic                   out_ready,
    output logic [31:0]            out_data,
    output logic                   out_valid,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LEVEL_ONE  = (AW+1)'(1);
    localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

    fp_32_t        mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          full;
    logic          pop;
    logic          do_push;

    assign out_valid = (level != '0);
    assign full      = (level == LEVEL_FULL);
    assign pop       = out_valid && out_ready;
    assign do_push   = push && (!full || pop);

    always_ff @(posedge clock) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // out_data always mirrors the entry at rd_ptr, so after a pop it is refilled from
    // the next stored word, or from the incoming push when the buffer held just one.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            out_data <= '0;
        end else if (clear) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            out_data <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
            if (do_push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !do_push) begin
                level <= level - 1'b1;
            end
            if (pop) begin
                if (level > LEVEL_ONE) begin
                    out_data <= mem[rd_ptr + 1'b1];
                end else if (do_push) begin
                    out_data <= push_data;
                end
            end else if (!out_valid && do_push) begin
                out_data <= push_data;
            end
        end
    end

endmodule

// File: rtl/fir_output_decimator.sv
// fir_output_decimator: discards filter warm-up samples, decimates by DECIM and buffers results.
// Define FIR_DECIM_ACCUMULATE_EN to integrate-and-dump each group instead of keeping its last sample.
module fir_output_decimator
    import fir_output_decimator_pkg::fir_decim_state_t;
#(
    parameter int DECIM      = 4,
    parameter int WARMUP     = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clock,
    input  logic                        resetN,
    input  logic                        run,
    input  logic                        clear,
    input  logic [31:0]                 y_in,
    output logic [31:0]                 out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow
);

    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

    // The WARMUP parameter shadows the enum literal, so the states get local aliases.
    localparam fir_decim_state_t S_IDLE   = fir_output_decimator_pkg::IDLE;
    localparam fir_decim_state_t S_WARM   = fir_output_decimator_pkg::WARMUP;
    localparam fir_decim_state_t S_STREAM = fir_output_decimator_pkg::STREAM;

    fir_decim_state_t state;
    logic [WW-1:0]    warm_cnt;
    logic [PW-1:0]    phase_cnt;
    logic             stream_sample;
    logic             group_end;
    logic             warm_done;
    logic             push;
    logic [31:0]      push_data;

    assign stream_sample = run && ((state == S_STREAM) || (state == S_IDLE && WARMUP == 0));
    assign group_end     = (int'(phase_cnt) == DECIM - 1);
    assign warm_done     = (int'(warm_cnt) == WARMUP - 1);
    assign push          = stream_sample && group_end && !clear;

    // The edge that first sees run high already consumes a sample, so IDLE counts it too.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state     <= S_IDLE;
            warm_cnt  <= '0;
            phase_cnt <= '0;
        end else if (clear || !run) begin
            state     <= S_IDLE;
            warm_cnt  <= '0;
            phase_cnt <= '0;
        end else begin
            case (state)
                S_IDLE, S_WARM: begin
                    if (WARMUP == 0) begin
                        state     <= S_STREAM;
                        phase_cnt <= group_end ? '0 : phase_cnt + 1'b1;
                    end else if (warm_done) begin
                        state    <= S_STREAM;
                        warm_cnt <= '0;
                    end else begin
                        state    <= S_WARM;
                        warm_cnt <= warm_cnt + 1'b1;
                    end
                end
                default: begin
                    phase_cnt <= group_end ? '0 : phase_cnt + 1'b1;
                end
            endcase
        end
    end

`ifdef FIR_DECIM_ACCUMULATE_EN
    logic signed [33:0] acc;
    logic signed [33:0] group_sum;

    assign group_sum = (phase_cnt == '0) ? 34'(signed'(y_in)) : acc + 34'(signed'(y_in));
    assign push_data = fir_output_decimator_pkg::sat_fp_32(group_sum);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            acc <= '0;
        end else if (clear || !run) begin
            acc <= '0;
        end else if (stream_sample) begin
            acc <= group_sum;
        end
    end
`else
    assign push_data = y_in;
`endif

    fir_out_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .resetN   (resetN),
        .clear    (clear),
        .push     (push),
        .push_data(push_data),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .level    (fifo_level),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_fir_output_decimator.sv
// Bench for fir_output_decimator: directed scenarios plus random traffic against a queue-based model.
module tb_fir_output_decimator;

    localparam int DECIM = 4;
    localparam int WARMUP = 4;
    localparam int DEPTH = 8;
    localparam longint SMAX = 64'sh7FFF_FFFF;
    localparam longint SMIN = -SMAX - 1;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic        run = 1'b0;
    logic        clear = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] y_in = '0;
    logic [31:0] out_data;
    logic        out_valid;
    logic [3:0]  fifo_level;
    logic        overflow;

    int total = 0;
    int bad = 0;

    logic [31:0] mq[$];
    logic [31:0] grp[$];
    int          seen = 0;
    bit          movf = 1'b0;

    always #5 clock = ~clock;

    fir_output_decimator #(
        .DECIM(DECIM),
        .WARMUP(WARMUP),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock     (clock),
        .resetN    (resetN),
        .run       (run),
        .clear     (clear),
        .y_in      (y_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fifo_level(fifo_level),
        .overflow  (overflow)
    );

    function automatic logic [31:0] groupValue();
`ifdef FIR_DECIM_ACCUMULATE_EN
        longint sum = 0;
        foreach (grp[i]) sum += longint'(signed'(grp[i]));
        if (sum > SMAX) return 32'h7FFF_FFFF;
        if (sum < SMIN) return 32'h8000_0000;
        return sum[31:0];
`else
        return grp[grp.size() - 1];
`endif
    endfunction

    function automatic logic [31:0] expectAcc(input logic [31:0] accVal, input logic [31:0] lastVal);
`ifdef FIR_DECIM_ACCUMULATE_EN
        return accVal;
`else
        return lastVal;
`endif
    endfunction

    task automatic modelReset();
        mq.delete();
        grp.delete();
        seen = 0;
        movf = 1'b0;
    endtask

    // One clock edge of behaviour: count accepted samples since run rose, collect groups.
    task automatic modelStep(input bit r, input bit c, input logic [31:0] y, input bit rdy);
        bit          pop;
        bit          havePush;
        logic [31:0] val;
        pop = (mq.size() > 0) && rdy;
        havePush = 1'b0;
        val = '0;
        if (c) begin
            modelReset();
            return;
        end
        if (r) begin
            seen++;
            if (seen > WARMUP) begin
                grp.push_back(y);
                if (grp.size() == DECIM) begin
                    val = groupValue();
                    grp.delete();
                    havePush = 1'b1;
                end
            end
        end else begin
            seen = 0;
            grp.delete();
        end
        if (pop) void'(mq.pop_front());
        if (havePush) begin
            if (mq.size() < DEPTH) mq.push_back(val);
            else movf = 1'b1;
        end
    endtask

    task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkOne("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        checkOne("fifo_level", 32'(fifo_level), 32'(mq.size()));
        checkOne("overflow", 32'(overflow), 32'(movf));
        if (mq.size() > 0) checkOne("out_data", out_data, mq[0]);
    endtask

    task automatic applyStimulus(input bit r, input bit c, input logic [31:0] y, input bit rdy);
        run = r;
        clear = c;
        y_in = y;
        out_ready = rdy;
        @(posedge clock);
        modelStep(r, c, y, rdy);
        #1;
        checkOutput();
    endtask

    initial begin
        modelReset();
        $display("[TB] reset");
        repeat (3) @(posedge clock);
        #1;
        checkOne("rst_valid", 32'(out_valid), 0);
        checkOne("rst_level", 32'(fifo_level), 0);
        checkOne("rst_overflow", 32'(overflow), 0);
        checkOne("rst_data", out_data, 0);
        @(negedge clock);
        resetN = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, $urandom, 1'b1);

        $display("[TB] basic stream");
        for (int i = 1; i <= 24; i++) begin
            applyStimulus(1'b1, 1'b0, 32'(i), 1'b1);
            if (i == 8) checkOne("first_group", out_data, expectAcc(32'd26, 32'd8));
            if (i == 12) checkOne("second_group", out_data, expectAcc(32'd42, 32'd12));
        end

        $display("[TB] stall and overflow");
        applyStimulus(1'b0, 1'b1, '0, 1'b0);
        for (int i = 1; i <= 40; i++) applyStimulus(1'b1, 1'b0, 32'(i), 1'b0);
        checkOne("stall_level", 32'(fifo_level), 8);
        checkOne("stall_overflow", 32'(overflow), 1);
        for (int k = 0; k < 8; k++) begin
            checkOne("drain_order", out_data, expectAcc(32'(16 * k + 26), 32'(8 + 4 * k)));
            applyStimulus(1'b0, 1'b0, '0, 1'b1);
        end
        checkOne("drained_valid", 32'(out_valid), 0);

        $display("[TB] mid-group run drop");
        applyStimulus(1'b0, 1'b1, '0, 1'b1);
        for (int i = 1; i <= 10; i++) applyStimulus(1'b1, 1'b0, 32'(i), 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 32'(100 + i), 1'b1);
        checkOne("rerun_valid", 32'(out_valid), 1);
        checkOne("rerun_data", out_data, expectAcc(32'd422, 32'd107));

        $display("[TB] saturation limits");
        applyStimulus(1'b0, 1'b1, '0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'(i), 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1);
        checkOne("sat_max", out_data, 32'h7FFF_FFFF);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'h8000_0000, 1'b1);
        checkOne("sat_min", out_data, 32'h8000_0000);

        $display("[TB] clear with buffered data");
        applyStimulus(1'b0, 1'b1, '0, 1'b0);
        for (int i = 1; i <= 24; i++) applyStimulus(1'b1, 1'b0, $urandom, 1'b0);
        checkOne("buffered_level", 32'(fifo_level), 5);
        applyStimulus(1'b1, 1'b1, $urandom, 1'b0);
        checkOne("clear_level", 32'(fifo_level), 0);
        checkOne("clear_overflow", 32'(overflow), 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 15) != 0, $urandom_range(0, 79) == 0,
                          $urandom, (i % 100 < 60) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0));
        end

        $display("[TB] asynchronous reset between edges");
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, $urandom, 1'b0);
        #3;
        resetN = 1'b0;
        #1;
        modelReset();
        checkOne("arst_valid", 32'(out_valid), 0);
        checkOne("arst_level", 32'(fifo_level), 0);
        checkOne("arst_overflow", 32'(overflow), 0);
        checkOne("arst_data", out_data, 0);
        run = 1'b0;
        clear = 1'b0;
        @(negedge clock);
        resetN = 1'b1;
        for (int i = 1; i <= 12; i++) applyStimulus(1'b1, 1'b0, 32'(i), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
